vecmax_sub_ser: RTL and testbench

- Stage directly downstream of the vector-maximum block, used as the front end of a softmax / log-sum-exp path.
- Accepts a COLS-element signed fixed-point vector while the same vector drives the vecmax input.
- One cycle later, takes the registered maximum from vecmax.
- Emits d[i] = a[i] - max serially, one element per beat, over a valid/ready stream.

---
 rtl/vecmax_pkg.sv | 15 +
 rtl/vecmax_sub_ser_sat_sub.sv | 24 ++
 rtl/vecmax_sub_ser.sv | 93 +++++++++
 tb/tb_vecmax_sub_ser.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vecmax_pkg.sv
// Shared types for the vecmax subtract/serialise stage: FSM state encoding and index sizing.
package vecmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAITMAX,
    EMIT
  } state_t;

  // Index runs 1..COLS, so it needs enough bits to hold COLS itself.
  function automatic int idx_w(input int cols);
    return $clog2(cols + 1);
  endfunction

endpackage

// File: rtl/vecmax_sub_ser_sat_sub.sv
// Signed a-b at WIDTH+1 bits, reduced to WIDTH bits.
// VECMAX_SUB_SAT_EN defined: clamp to -2^(WIDTH-1); undefined: two's-complement wrap.
module sat_sub #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_y
);

`ifdef VECMAX_SUB_SAT_EN
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_min;

  assign w_diff = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
  assign w_min  = {1'b1, {(WIDTH-1){1'b0}}};
  // Negative and the top two bits disagree: below the representable minimum.
  assign o_y    = (w_diff[WIDTH] && !w_diff[WIDTH-1]) ? w_min : w_diff[WIDTH-1:0];
`else
  // The low WIDTH bits of the extended difference equal the plain WIDTH-bit difference.
  assign o_y = i_a - i_b;
`endif

endmodule

// File: rtl/vecmax_sub_ser.sv
// Captures a vector alongside vecmax, takes the registered max one cycle later and
// streams a[i]-max one element per beat. Optional saturation: VECMAX_SUB_SAT_EN.
module vecmax_sub_ser
  import vecmax_pkg::*;
#(
  parameter int COLS  = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COLS*WIDTH-1:0]    in_vec,
  input  logic [WIDTH-1:0]         max_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [idx_w(COLS)-1:0]   out_idx,
  output logic                     out_last
);

  localparam int            IW   = idx_w(COLS);
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] LAST = IW'(COLS);

  state_t           r_state;
  logic [WIDTH-1:0] r_vec [1:COLS];
  logic [WIDTH-1:0] r_max;

  logic [IW-1:0]    w_nxt_idx;
  logic [IW-1:0]    w_sel_idx;
  logic [WIDTH-1:0] w_sel_max;
  logic [WIDTH-1:0] w_diff;

  // The subtractor always prepares the beat that will be loaded at the next edge.
  assign w_nxt_idx = out_idx + ONE;
  assign w_sel_idx = (r_state == EMIT && out_idx != LAST) ? w_nxt_idx : ONE;
  assign w_sel_max = (r_state == WAITMAX) ? max_in : r_max;

  sat_sub #(.WIDTH(WIDTH)) u_sub (
    .i_a (r_vec[w_sel_idx]),
    .i_b (w_sel_max),
    .o_y (w_diff)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= ONE;
      out_data  <= '0;
      r_max     <= '0;
      for (int i = 1; i <= COLS; i++) r_vec[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 1; i <= COLS; i++) r_vec[i] <= in_vec[i*WIDTH-1 -: WIDTH];
            in_ready <= 1'b0;
            r_state  <= WAITMAX;
          end
        end
        WAITMAX: begin
          r_max     <= max_in;
          out_idx   <= ONE;
          out_data  <= w_diff;
          out_last  <= (LAST == ONE);
          out_valid <= 1'b1;
          r_state   <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (out_idx == LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= ONE;
              in_ready  <= 1'b1;
              r_state   <= IDLE;
            end else begin
              out_idx  <= w_nxt_idx;
              out_data <= w_diff;
              out_last <= (w_nxt_idx == LAST);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vecmax_sub_ser.sv
// Directed bench for vecmax_sub_ser: COLS=4/WIDTH=16, COLS=2/WIDTH=8 and COLS=1 instances.
module tb_vecmax_sub_ser;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // ---- instance A: COLS=4, WIDTH=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [63:0] a_vec;
  logic [15:0] a_max, a_out_data;
  logic [2:0]  a_out_idx;

  vecmax_sub_ser #(.COLS(4), .WIDTH(16)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_vec(a_vec), .max_in(a_max), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last));

  // ---- instance B: COLS=2, WIDTH=8
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_vec;
  logic [7:0]  b_max, b_out_data;
  logic [1:0]  b_out_idx;

  vecmax_sub_ser #(.COLS(2), .WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vec(b_vec), .max_in(b_max), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last));

  // ---- instance C: COLS=1, WIDTH=16
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [15:0] c_vec, c_max, c_out_data;
  logic [0:0]  c_out_idx;

  vecmax_sub_ser #(.COLS(1), .WIDTH(16)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_vec(c_vec), .max_in(c_max), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_idx(c_out_idx), .out_last(c_out_last));

  // Stand-in for vecmax: registered maximum of whatever is on the vector bus.
  function automatic logic [15:0] vmax4(input logic [63:0] v);
    logic signed [15:0] m, e;
    m = v[15:0];
    for (int i = 1; i < 4; i++) begin
      e = v[i*16 +: 16];
      if (e > m) m = e;
    end
    return m;
  endfunction

  always @(posedge clk) begin
    a_max <= vmax4(a_vec);
    b_max <= ($signed(b_vec[15:8]) > $signed(b_vec[7:0])) ? b_vec[15:8] : b_vec[7:0];
    c_max <= c_vec;
  end

  function automatic logic [63:0] pack4(input int e1, input int e2, input int e3, input int e4);
    return {e4[15:0], e3[15:0], e2[15:0], e1[15:0]};
  endfunction

  task automatic beat_a(input string tag, input int d, input int idx, input int last);
    chk({tag, "_vld"},  int'(a_out_valid), 1);
    chk({tag, "_data"}, int'($signed(a_out_data)), d);
    chk({tag, "_idx"},  int'(a_out_idx), idx);
    chk({tag, "_last"}, int'(a_out_last), last);
  endtask

  // Offer a vector for one cycle; returns at the negedge where beat 1 is visible.
  task automatic send_a(input logic [63:0] v);
    @(negedge clk);
    a_vec = v;
    a_in_valid = 1'b1;
    chk("a_acc_rdy", int'(a_in_ready), 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("a_wait_rdy", int'(a_in_ready), 0);
    chk("a_wait_vld", int'(a_out_valid), 0);
    @(negedge clk);
  endtask

  task automatic rx_all_a(input string tag, input int e [4]);
    for (int i = 0; i < 4; i++) begin
      beat_a(tag, e[i], i + 1, (i == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk({tag, "_end_vld"}, int'(a_out_valid), 0);
    chk({tag, "_end_rdy"}, int'(a_in_ready), 1);
  endtask

  int          exp1 [4] = '{-200, -305, 0, -293};
  int          exp2 [4] = '{-30, -20, -10, 0};
  logic [63:0] v1, v2;
  int          exp_wrap;

  initial begin
    v1 = pack4(100, -5, 300, 7);
    v2 = pack4(-40, -30, -20, -10);
`ifdef VECMAX_SUB_SAT_EN
    exp_wrap = -128;
`else
    exp_wrap = 1;
`endif
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_vec = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_vec = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_vec = '0;

    repeat (2) @(negedge clk);
    chk("rst_rdy",  int'(a_in_ready), 1);
    chk("rst_vld",  int'(a_out_valid), 0);
    chk("rst_last", int'(a_out_last), 0);
    chk("rst_idx",  int'(a_out_idx), 1);
    chk("rst_data", int'($signed(a_out_data)), 0);
    chk("rst_b_vld", int'(b_out_valid), 0);
    chk("rst_c_rdy", int'(c_in_ready), 1);
    reset = 1'b0;

    // Basic vector, out_ready held high
    send_a(v1);
    rx_all_a("basic", exp1);

    // Backpressure during beat 2
    send_a(v1);
    beat_a("bp1", -200, 1, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      beat_a("bp2", -305, 2, 0);
      if (k == 0) a_out_ready = 1'b0;
      if (k == 3) a_out_ready = 1'b1;
      @(negedge clk);
    end
    beat_a("bp3", 0, 3, 0);
    @(negedge clk);
    beat_a("bp4", -293, 4, 1);
    @(negedge clk);
    chk("bp_end_vld", int'(a_out_valid), 0);

    // Second vector held on the bus during EMIT must wait for the last handshake
    send_a(v1);
    a_vec = v2;
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat_a("blk", exp1[i], i + 1, (i == 3) ? 1 : 0);
      chk("blk_rdy", int'(a_in_ready), 0);
      @(negedge clk);
    end
    chk("blk_idle_rdy", int'(a_in_ready), 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("blk_wait_rdy", int'(a_in_ready), 0);
    chk("blk_wait_vld", int'(a_out_valid), 0);
    @(negedge clk);
    rx_all_a("blk2", exp2);

    // Reset during beat 2
    send_a(v1);
    beat_a("mr1", -200, 1, 0);
    @(negedge clk);
    beat_a("mr2", -305, 2, 0);
    reset = 1'b1;
    #1;
    chk("mr_vld",  int'(a_out_valid), 0);
    chk("mr_rdy",  int'(a_in_ready), 1);
    chk("mr_idx",  int'(a_out_idx), 1);
    chk("mr_last", int'(a_out_last), 0);
    @(negedge clk);
    reset = 1'b0;
    send_a(v2);
    rx_all_a("mr_new", exp2);

    // WIDTH=8, COLS=2: {-128, 127}
    @(negedge clk);
    b_vec = {8'h7F, 8'h80};
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("w8_wait_vld", int'(b_out_valid), 0);
    @(negedge clk);
    chk("w8_b1_vld",  int'(b_out_valid), 1);
    chk("w8_b1_data", int'($signed(b_out_data)), exp_wrap);
    chk("w8_b1_idx",  int'(b_out_idx), 1);
    chk("w8_b1_last", int'(b_out_last), 0);
    @(negedge clk);
    chk("w8_b2_data", int'($signed(b_out_data)), 0);
    chk("w8_b2_idx",  int'(b_out_idx), 2);
    chk("w8_b2_last", int'(b_out_last), 1);
    @(negedge clk);
    chk("w8_end_vld", int'(b_out_valid), 0);
    chk("w8_end_rdy", int'(b_in_ready), 1);

    // COLS=1: {-42}
    @(negedge clk);
    c_vec = 16'hFFD6;
    c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    chk("c1_wait_rdy", int'(c_in_ready), 0);
    @(negedge clk);
    chk("c1_vld",  int'(c_out_valid), 1);
    chk("c1_data", int'($signed(c_out_data)), 0);
    chk("c1_idx",  int'(c_out_idx), 1);
    chk("c1_last", int'(c_out_last), 1);
    @(negedge clk);
    chk("c1_end_vld", int'(c_out_valid), 0);
    chk("c1_end_rdy", int'(c_in_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
